io_out_fifo: RTL and testbench
==============================

# io_out_fifo

Output-side I/O buffer placed directly downstream of the processor core's output interface. On every `out_en` strobe it captures the core's output word (`data_out`) together with its port address (`addr_out`) into a show-ahead FIFO. It then drains the entries to the external output ports through a valid/ready handshake. It also keeps one shadow register per output address, holding the last value written to that address, and flags writes dropped on overflow, since the core has no stall input.

## Interface
- `NUBITS`, 32, data word width; must match the core.
- `NUIOOU`, 8, number of output addresses; address width is `$clog2(NUIOOU)`.
- `FDEPTH`, 8, FIFO entries; must be a power of two and ≥2.
- `clk`  in  1  clock; all logic updates on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-low (`rst`=0 resets on the next rising edge).
- `out_en`  in  1  write strobe from the core, qualifying `addr_out`/`data_out` in the same cycle.
- `addr_out`  in  `$clog2(NUIOOU)`  output port address from the core.
- `data_out`  in  `NUBITS`  output word from the core.
- `port_valid`  out  1  FIFO head entry is valid.
- `port_ready`  in  1  consumer accepts the head entry this cycle.
- `port_addr`  out  `$clog2(NUIOOU)`  address of the head entry.
- `port_data`  out  `NUBITS`  data of the head entry.
- `shadow`  out  `NUIOOU*NUBITS`  last value written per address; address a occupies bits `[a*NUBITS +: NUBITS]`.
- `count`  out  `$clog2(FDEPTH)+1`  number of occupied entries.
- `full`  out  1  `count == FDEPTH`.
- `overflow`  out  1  sticky flag: at least one write was dropped.

## Operation
- Storage: `FDEPTH` x (addr+data) array, write pointer `wp`, read pointer `rp` (each `$clog2(FDEPTH)` bits, natural wrap), registered `count`.
- Head is show-ahead: `port_addr`/`port_data` = array[`rp`] combinationally; `port_valid` = (`count` != 0).
- Pop: `pop = port_valid & port_ready`; on the edge, `rp` increments by 1.
- Push request: `out_en`=1.
  - Push is accepted when `count < FDEPTH` or `pop`=1 in the same cycle.
  - On acceptance: array[`wp`] <= {`addr_out`, `data_out`}; `wp` increments by 1.
- Dropped push: `out_en`=1, `full`=1 and `pop`=0.
  - Entry is discarded; pointers and `count` are unchanged.
  - `overflow` <= 1; it is cleared only by reset.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Shadow: on every `out_en`=1, `shadow[addr_out]` <= `data_out`, independent of FIFO acceptance, so dropped writes still update the shadow.
  - Addresses ≥ `NUIOOU` (possible when `NUIOOU` is not a power of two) update no shadow; the FIFO entry is still pushed.
- `port_ready` while `port_valid`=0 has no effect.
- Reset (`rst`=0 at an edge) overrides everything:
  - `wp`=`rp`=0, `count`=0, `overflow`=0, all `shadow`=0.
  - Array contents are don't-care.
  - A push or pop in the reset cycle is ignored.

## Timing
- Reset values: `port_valid`=0, `count`=0, `full`=0, `overflow`=0, `shadow`=0. `port_addr`/`port_data` are undefined while `port_valid`=0.
- Write-to-valid latency is 1 cycle: `out_en` sampled at edge k makes `port_valid`=1 from after edge k when the FIFO was empty.
- No bypass: an empty FIFO never presents same-cycle input data at the head.
- One push and one pop per cycle, maximum; sustained throughput is 1 entry/cycle.
- `port_addr`/`port_data` must stay stable while `port_valid`=1 and `port_ready`=0.
- Ordering is strict FIFO; pointers wrap from `FDEPTH-1` to 0 with no gap.
- Shadow update latency is 1 cycle after the `out_en` edge.

## Test plan
- Reset, then single write: drive `rst`=0 for 2 cycles, then `out_en`=1, `addr_out`=3, `data_out`=0x0000_00AB for 1 cycle with `port_ready`=0.
  - Next cycle: `port_valid`=1, `port_addr`=3, `port_data`=0xAB, `count`=1, `shadow[3]`=0xAB.
  - Asserting `port_ready`=1 for 1 cycle gives `port_valid`=0, `count`=0.
- Fill and overflow: `port_ready`=0, 9 consecutive writes of data 1..9.
  - `full`=1 after the 8th; the 9th is dropped and `overflow`=1.
  - Draining returns 1..8 in order; `shadow` holds 9 at the written address.
- Full with simultaneous push and pop: 8 entries held, then `out_en`=1 (data 0x55) and `port_ready`=1 in one cycle.
  - Push accepted, `count` stays 8, `overflow` stays 0, and 0x55 emerges last.
- Streaming wrap-around: 20 writes on consecutive cycles with `port_ready`=1 throughout.
  - Output sequence equals input sequence; `count` ≤ 1 always; no overflow.
- Backpressure stability: head entry (addr 5, 0x1234) held with `port_ready`=0 for 10 cycles while 3 more writes arrive.
  - Head is unchanged throughout; `count` goes 1 to 4.
- Mid-operation reset: with 5 entries queued and `overflow`=1, pulse `rst`=0 for 1 cycle during which `out_en`=1.
  - Next cycle: `count`=0, `port_valid`=0, `overflow`=0, all `shadow`=0; the write in the reset cycle is lost.

Source files
------------

// File: rtl/io_out_fifo.sv
// ---------------------------------------------------------------------------
// io_out_fifo
//
// Output-side buffer between the processor core's output interface and the
// external output ports. The core cannot be stalled, so every out_en strobe
// is either captured into a show-ahead FIFO or, when the FIFO is full and
// nothing leaves that cycle, dropped and recorded in a sticky overflow flag.
// Independently of the FIFO, a shadow register per output address keeps the
// last value the core wrote to that address (dropped writes included).
//
// Parameters
//   NUBITS  data word width (must match the core)
//   NUIOOU  number of output addresses; address width is $clog2(NUIOOU)
//   FDEPTH  FIFO depth; power of two, at least 2
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-low reset
//   out_en      write strobe from the core, qualifies addr_out/data_out
//   addr_out    output port address from the core
//   data_out    output word from the core
//   port_valid  head entry valid (FIFO not empty)
//   port_ready  consumer accepts the head entry this cycle
//   port_addr   address of the head entry
//   port_data   data of the head entry
//   shadow      last value per address, address a at [a*NUBITS +: NUBITS]
//   count       number of occupied FIFO entries
//   full        count == FDEPTH
//   overflow    sticky: at least one write was dropped since reset
// ---------------------------------------------------------------------------
module io_out_fifo #(
    parameter int NUBITS = 32,
    parameter int NUIOOU = 8,
    parameter int FDEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         out_en,
    input  logic [$clog2(NUIOOU)-1:0]    addr_out,
    input  logic [NUBITS-1:0]            data_out,
    output logic                         port_valid,
    input  logic                         port_ready,
    output logic [$clog2(NUIOOU)-1:0]    port_addr,
    output logic [NUBITS-1:0]            port_data,
    output logic [NUIOOU*NUBITS-1:0]     shadow,
    output logic [$clog2(FDEPTH):0]      count,
    output logic                         full,
    output logic                         overflow
);

    localparam int AW = $clog2(NUIOOU);
    localparam int PW = $clog2(FDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FDEPTH);

    // Entry storage. Address and data live in separate arrays of the same
    // depth; neither is reset because only the pointers give them meaning.
    logic [AW-1:0]     mem_addr [FDEPTH];
    logic [NUBITS-1:0] mem_data [FDEPTH];

    logic [PW-1:0]     wp;
    logic [PW-1:0]     rp;

    logic [NUBITS-1:0] shadow_r [NUIOOU];

    logic              pop;
    logic              push;
    logic              drop;

    // Show-ahead head: the entry at rp is visible as soon as count is
    // non-zero, with no bypass from the write side.
    assign port_valid = (count != '0);
    assign full       = (count == DEPTH_C);
    assign port_addr  = mem_addr[rp];
    assign port_data  = mem_data[rp];

    // A pop in the same cycle frees a slot, so a full FIFO still accepts
    // a write while it is being drained.
    assign pop  = port_valid & port_ready;
    assign push = out_en & (~full | pop);
    assign drop = out_en & full & ~pop;

    // Entry write. Gated by rst so a write in the reset cycle never lands,
    // although the array contents are meaningless after reset anyway.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_addr[wp] <= addr_out;
            mem_data[wp] <= data_out;
        end
    end

    // Pointers, occupancy and the sticky overflow flag. Pointers are PW
    // bits wide and wrap naturally because FDEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + PW'(1);
            end
            if (pop) begin
                rp <= rp + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Shadow registers follow every strobe, accepted or dropped. Addresses
    // at or above NUIOOU (only reachable when NUIOOU is not a power of two)
    // match no register and leave the shadow untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUIOOU; i++) begin
                shadow_r[i] <= '0;
            end
        end else if (out_en) begin
            for (int i = 0; i < NUIOOU; i++) begin
                if (addr_out == AW'(i)) begin
                    shadow_r[i] <= data_out;
                end
            end
        end
    end

    for (genvar a = 0; a < NUIOOU; a++) begin : g_shadow_out
        assign shadow[a*NUBITS +: NUBITS] = shadow_r[a];
    end

endmodule

// File: tb/tb_io_out_fifo.sv
// ---------------------------------------------------------------------------
// tb_io_out_fifo
//
// Scoreboard bench for io_out_fifo. The driver applies one cycle of stimulus
// at a time and advances a queue-based reference model on the same edge:
// accepted writes are appended to the expected-entry queue, occupancy and
// the overflow flag are tracked as plain numbers, and the shadow is an array
// indexed by address. A monitor on the falling edge compares the DUT's
// status outputs with the model and, whenever the DUT presents a head entry,
// compares it with the oldest expected entry, retiring it on a handshake.
// ---------------------------------------------------------------------------
module tb_io_out_fifo;

    localparam int NUBITS = 32;
    localparam int NUIOOU = 8;
    localparam int FDEPTH = 8;
    localparam int AW     = $clog2(NUIOOU);
    localparam int CW     = $clog2(FDEPTH) + 1;

    logic                      clk        = 1'b0;
    logic                      rst        = 1'b0;
    logic                      out_en     = 1'b0;
    logic [AW-1:0]             addr_out   = '0;
    logic [NUBITS-1:0]         data_out   = '0;
    logic                      port_ready = 1'b0;
    logic                      port_valid;
    logic [AW-1:0]             port_addr;
    logic [NUBITS-1:0]         port_data;
    logic [NUIOOU*NUBITS-1:0]  shadow;
    logic [CW-1:0]             count;
    logic                      full;
    logic                      overflow;

    io_out_fifo #(
        .NUBITS (NUBITS),
        .NUIOOU (NUIOOU),
        .FDEPTH (FDEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .out_en     (out_en),
        .addr_out   (addr_out),
        .data_out   (data_out),
        .port_valid (port_valid),
        .port_ready (port_ready),
        .port_addr  (port_addr),
        .port_data  (port_data),
        .shadow     (shadow),
        .count      (count),
        .full       (full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrs   = 0;

    // Reference model state.
    logic [AW+NUBITS-1:0] exp_q [$];
    int                   mcnt  = 0;
    bit                   movf  = 1'b0;
    logic [NUBITS-1:0]    msh [NUIOOU];
    bit                   mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nchecks++;
        if (act !== req) begin
            nerrs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // One clock of stimulus; the model is advanced on the same rising edge.
    task automatic cyc(input bit oe, input int a, input logic [NUBITS-1:0] d,
                       input bit rdy, input bit r);
        bit mpop;
        bit acc;
        out_en     = oe;
        addr_out   = AW'(a);
        data_out   = d;
        port_ready = rdy;
        rst        = r;
        @(posedge clk);
        if (!r) begin
            mcnt = 0;
            movf = 1'b0;
            exp_q.delete();
            foreach (msh[i]) msh[i] = '0;
        end else begin
            mpop = (mcnt != 0) && rdy;
            acc  = 1'b0;
            if (oe) begin
                if (a < NUIOOU) msh[a] = d;
                if (mcnt < FDEPTH || mpop) begin
                    acc = 1'b1;
                    exp_q.push_back({AW'(a), d});
                end else begin
                    movf = 1'b1;
                end
            end
            mcnt = mcnt + int'(acc) - int'(mpop);
        end
        #1;
    endtask

    function automatic logic [NUBITS-1:0] shadow_at(input int a);
        return shadow[a*NUBITS +: NUBITS];
    endfunction

    // Monitor: status against the model, head against the scoreboard.
    always @(negedge clk) begin
        logic [AW+NUBITS-1:0] head;
        if (mon_en) begin
            chk("count", 64'(count), 64'(mcnt));
            chk("port_valid", 64'(port_valid), 64'(mcnt != 0));
            chk("full", 64'(full), 64'(mcnt == FDEPTH));
            chk("overflow", 64'(overflow), 64'(movf));
            for (int a = 0; a < NUIOOU; a++) begin
                chk("shadow", 64'(shadow_at(a)), 64'(msh[a]));
            end
            if (port_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    nchecks++;
                    nerrs++;
                    $display("FAIL head: DUT presents addr %0d data 0x%0h, scoreboard empty",
                             port_addr, port_data);
                end else begin
                    head = exp_q[0];
                    chk("head_addr", 64'(port_addr), 64'(head[AW+NUBITS-1:NUBITS]));
                    chk("head_data", 64'(port_data), 64'(head[NUBITS-1:0]));
                    if (port_ready === 1'b1) begin
                        head = exp_q.pop_front();
                    end
                end
            end
        end
    end

    initial begin
        foreach (msh[i]) msh[i] = '0;

        // Reset for two cycles, then check the idle state.
        cyc(1'b0, 0, '0, 1'b0, 1'b0);
        cyc(1'b0, 0, '0, 1'b0, 1'b0);
        mon_en = 1'b1;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_valid", 64'(port_valid), 64'd0);
        chk("reset_full", 64'(full), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_shadow", 64'(|shadow), 64'd0);

        // Single write, visible one cycle later, then popped.
        cyc(1'b1, 3, 32'h0000_00AB, 1'b0, 1'b1);
        chk("t1_valid", 64'(port_valid), 64'd1);
        chk("t1_addr", 64'(port_addr), 64'd3);
        chk("t1_data", 64'(port_data), 64'hAB);
        chk("t1_count", 64'(count), 64'd1);
        chk("t1_shadow3", 64'(shadow_at(3)), 64'hAB);
        cyc(1'b0, 0, '0, 1'b1, 1'b1);
        chk("t1_valid_after_pop", 64'(port_valid), 64'd0);
        chk("t1_count_after_pop", 64'(count), 64'd0);

        // Fill and overflow: nine writes 1..9 with no consumer.
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b1, 2, NUBITS'(i), 1'b0, 1'b1);
            if (i == 7) chk("t2_not_full_at7", 64'(full), 64'd0);
            if (i == 8) chk("t2_full_at8", 64'(full), 64'd1);
            if (i == 8) chk("t2_no_ovf_at8", 64'(overflow), 64'd0);
        end
        chk("t2_overflow", 64'(overflow), 64'd1);
        chk("t2_count", 64'(count), 64'd8);
        chk("t2_head_first", 64'(port_data), 64'd1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 0, '0, 1'b1, 1'b1);
        chk("t2_drained", 64'(count), 64'd0);
        chk("t2_shadow2", 64'(shadow_at(2)), 64'd9);

        // Full with a simultaneous push and pop.
        cyc(1'b0, 0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, i, NUBITS'(32'h100 + i), 1'b0, 1'b1);
        cyc(1'b1, 1, 32'h55, 1'b1, 1'b1);
        chk("t3_count", 64'(count), 64'd8);
        chk("t3_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 0, '0, 1'b1, 1'b1);
        chk("t3_last_data", 64'(port_data), 64'h55);
        chk("t3_last_count", 64'(count), 64'd1);
        cyc(1'b0, 0, '0, 1'b1, 1'b1);

        // Streaming through the pointer wrap with the consumer always ready.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, i % NUIOOU, NUBITS'(32'hA000 + i), 1'b1, 1'b1);
            chk("t4_count_le1", 64'(count <= 1), 64'd1);
        end
        cyc(1'b0, 0, '0, 1'b1, 1'b1);
        chk("t4_count_end", 64'(count), 64'd0);
        chk("t4_overflow", 64'(overflow), 64'd0);

        // Backpressure: head held for ten cycles while three more arrive.
        cyc(1'b1, 5, 32'h1234, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(i < 3, 6, NUBITS'(32'hB0 + i), 1'b0, 1'b1);
            chk("t5_head_addr", 64'(port_addr), 64'd5);
            chk("t5_head_data", 64'(port_data), 64'h1234);
        end
        chk("t5_count", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, '0, 1'b1, 1'b1);

        // Mid-operation reset with five entries queued and overflow set.
        for (int i = 1; i <= 9; i++) cyc(1'b1, 7, NUBITS'(32'hC0 + i), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, '0, 1'b1, 1'b1);
        chk("t6_count_before", 64'(count), 64'd5);
        chk("t6_ovf_before", 64'(overflow), 64'd1);
        cyc(1'b1, 4, 32'h77, 1'b0, 1'b0);
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_valid", 64'(port_valid), 64'd0);
        chk("t6_overflow", 64'(overflow), 64'd0);
        chk("t6_shadow", 64'(|shadow), 64'd0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom % 3) != 0, int'($urandom % NUIOOU), $urandom,
                ($urandom % 2) != 0, ($urandom % 64) != 0);
        end
        for (int i = 0; i < FDEPTH + 2; i++) cyc(1'b0, 0, '0, 1'b1, 1'b1);
        chk("final_count", 64'(count), 64'd0);
        chk("final_scoreboard", 64'(exp_q.size()), 64'd0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
